cus43_tile_pixel_mixer: RTL

//  Downstream stage of the tilemap address generator. It captures graphics ROM

---
 rtl/cus43_tile_pixel_mixer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cus43_tile_pixel_mixer.sv
`default_nettype none
// ============================================================================
// Module   : cus43_tile_pixel_mixer
// Purpose  : Tilemap pixel back end. Captures graphics ROM data for two scroll
//            layers on their load strobes, serialises each layer to one pen
//            per CLK_6M (optionally in flipped order), and mixes the two
//            layers by transparency and priority into a single registered
//            pixel for the palette/priority compositor.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_6M    in   1   pixel clock, the only clock
//   RESET     in   1   synchronous active-high reset
//   HA2/HB2   in   1   layer A/B load strobes (one clock wide)
//   GD_A/GD_B in   16  layer graphics data, pixel0 in [3:0] when unflipped
//   ATTR_A/B  in   7   layer palette bank, captured with the strobe
//   PRI_A/B   in   3   layer priority (static, CPU latched)
//   FLIP      in   1   reverse pixel order of each load (captured per load)
//   HBLANK    in   1   horizontal blank, forces a blank output pixel
//   COL       out  11  {attr, pen} of the winning layer
//   OPRI      out  3   priority of the winning layer
//   OPAQUE    out  1   COL holds a valid non-transparent pixel
//   UNDERRUN  out  1   sticky: a layer ran dry outside blanking
// ============================================================================
module cus43_tile_pixel_mixer #(
    parameter int                  PEN_BITS     = 4,
    parameter int                  PIX_PER_LOAD = 4,
    parameter int                  ATTR_BITS    = 7,
    parameter logic [PEN_BITS-1:0] TRANS_PEN    = 4'hF
) (
    input  logic                             CLK_6M,
    input  logic                             RESET,
    input  logic                             HA2,
    input  logic                             HB2,
    input  logic [PEN_BITS*PIX_PER_LOAD-1:0] GD_A,
    input  logic [PEN_BITS*PIX_PER_LOAD-1:0] GD_B,
    input  logic [ATTR_BITS-1:0]             ATTR_A,
    input  logic [ATTR_BITS-1:0]             ATTR_B,
    input  logic [2:0]                       PRI_A,
    input  logic [2:0]                       PRI_B,
    input  logic                             FLIP,
    input  logic                             HBLANK,
    output logic [ATTR_BITS+PEN_BITS-1:0]    COL,
    output logic [2:0]                       OPRI,
    output logic                             OPAQUE,
    output logic                             UNDERRUN
);

    localparam int c_GD_W  = PEN_BITS * PIX_PER_LOAD;
    localparam int c_CNT_W = $clog2(PIX_PER_LOAD + 1);
    localparam int c_COL_W = ATTR_BITS + PEN_BITS;
    localparam int c_PRI_W = 3;

    // Layer index 0 is A, index 1 is B.
    logic [1:0]                 w_strobe;
    logic [1:0][c_GD_W-1:0]     w_gd;
    logic [1:0][ATTR_BITS-1:0]  w_attr_in;

    logic [1:0][PEN_BITS-1:0]   w_pen;
    logic [1:0]                 w_opaque;
    logic [1:0][ATTR_BITS-1:0]  w_attr_q;
    logic [1:0]                 w_dry;

    assign w_strobe  = {HB2, HA2};
    assign w_gd      = {GD_B, GD_A};
    assign w_attr_in = {ATTR_B, ATTR_A};

    // ------------------------------------------------------------------------
    // Per-layer serialiser: shift register, attribute latch, pixel counter.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_layer
        logic [c_GD_W-1:0]    r_sr;
        logic [ATTR_BITS-1:0] r_attr;
        logic [c_CNT_W-1:0]   r_cnt;
        logic                 r_flip;

        always_ff @(posedge CLK_6M) begin
            if (RESET) begin
                r_sr   <= '0;
                r_attr <= '0;
                r_cnt  <= '0;
                r_flip <= 1'b0;
            end else if (w_strobe[gi]) begin
                // A reload always wins, even mid-load; no merge with old data.
                r_sr   <= w_gd[gi];
                r_attr <= w_attr_in[gi];
                r_cnt  <= c_CNT_W'(PIX_PER_LOAD);
                r_flip <= FLIP;
            end else if (r_cnt != '0) begin
                // Flipped loads present the top nibble first, so shift the
                // next pen upward into that position.
                if (r_flip) begin
                    r_sr <= r_sr << PEN_BITS;
                end else begin
                    r_sr <= r_sr >> PEN_BITS;
                end
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end

        // An empty layer reads as transparent regardless of stale SR content.
        assign w_pen[gi]    = (r_cnt == '0) ? TRANS_PEN :
                              (r_flip ? r_sr[c_GD_W-1 -: PEN_BITS] : r_sr[PEN_BITS-1:0]);
        assign w_opaque[gi] = (r_cnt != '0) && (w_pen[gi] != TRANS_PEN);
        assign w_attr_q[gi] = r_attr;
        assign w_dry[gi]    = (r_cnt == '0) && !w_strobe[gi];
    end

    // ------------------------------------------------------------------------
    // Mix stage: pick the winning layer, register one pixel per clock.
    // ------------------------------------------------------------------------
    logic               w_sel_b;
    logic               w_any;
    logic [c_COL_W-1:0] w_col;
    logic [c_PRI_W-1:0] w_pri;

    always_comb begin
        w_sel_b = 1'b0;
        w_any   = w_opaque[0] || w_opaque[1];
        if (w_opaque[0] && w_opaque[1]) begin
            // Layer A wins ties.
            w_sel_b = (PRI_B > PRI_A);
        end else begin
            w_sel_b = w_opaque[1];
        end
        w_col = w_sel_b ? {w_attr_q[1], w_pen[1]} : {w_attr_q[0], w_pen[0]};
        w_pri = w_sel_b ? PRI_B : PRI_A;
    end

    logic [c_COL_W-1:0] r_col;
    logic [c_PRI_W-1:0] r_opri;
    logic               r_opaque;
    logic               r_underrun;

    always_ff @(posedge CLK_6M) begin
        if (RESET) begin
            r_col    <= '0;
            r_opri   <= '0;
            r_opaque <= 1'b0;
        end else if (HBLANK || !w_any) begin
            r_col    <= '0;
            r_opri   <= '0;
            r_opaque <= 1'b0;
        end else begin
            r_col    <= w_col;
            r_opri   <= w_pri;
            r_opaque <= 1'b1;
        end
    end

    // Sticky: only a reset clears a starvation event seen in active video.
    always_ff @(posedge CLK_6M) begin
        if (RESET) begin
            r_underrun <= 1'b0;
        end else if (!HBLANK && (w_dry != 2'b00)) begin
            r_underrun <= 1'b1;
        end
    end

    assign COL      = r_col;
    assign OPRI     = r_opri;
    assign OPAQUE   = r_opaque;
    assign UNDERRUN = r_underrun;

endmodule
`default_nettype wire
